// File: rtl/score_digit_reader.sv
// rtl/score_digit_reader.sv - streams packed-BCD score digits MSB-first with leading-zero blank flags
// Optional feature: define SCORE_HISCORE_EN to add the high-score register and an 8-digit stream.
module score_digit_reader #(
    parameter int BLANK_LEADING = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [15:0] score_in,
    input  logic        digit_ready,
    output logic        digit_valid,
    output logic [3:0]  digit_val,
    output logic [2:0]  digit_pos,
    output logic        digit_blank,
    output logic        busy,
`ifdef SCORE_HISCORE_EN
    output logic [15:0] hiscore,
`endif
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DONE
    } state_t;

`ifdef SCORE_HISCORE_EN
    localparam logic [2:0] LAST_POS = 3'd7;
`else
    localparam logic [2:0] LAST_POS = 3'd3;
`endif

    state_t      state_q, state_d;
    logic [15:0] snap_q, snap_d;
    logic [2:0]  pos_q, pos_d;
    logic [15:0] grp;
    logic [3:0]  nib;
    logic        lead_zero;

`ifdef SCORE_HISCORE_EN
    logic [15:0] hiscore_q, hiscore_d;
    assign hiscore = hiscore_q;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            snap_q    <= 16'h0000;
            pos_q     <= 3'd0;
`ifdef SCORE_HISCORE_EN
            hiscore_q <= 16'h0000;
`endif
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            pos_q     <= pos_d;
`ifdef SCORE_HISCORE_EN
            hiscore_q <= hiscore_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        pos_d     = pos_q;
`ifdef SCORE_HISCORE_EN
        hiscore_d = hiscore_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SEND;
                    snap_d  = score_in;
                    pos_d   = 3'd0;
`ifdef SCORE_HISCORE_EN
                    if (score_in > hiscore_q) begin
                        hiscore_d = score_in;
                    end
`endif
                end
            end
            S_SEND: begin
                if (digit_ready) begin
                    pos_d = pos_q + 3'd1;
                    if (pos_q == LAST_POS) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Upper four slots read the high score; the register only changes on an accepted start,
    // so it is as stable as the snapshot for the length of the stream.
    always_comb begin
        grp = snap_q;
`ifdef SCORE_HISCORE_EN
        if (pos_q[2]) begin
            grp = hiscore_q;
        end
`endif
        case (pos_q[1:0])
            2'd0: begin
                nib       = grp[15:12];
                lead_zero = (grp[15:12] == 4'h0);
            end
            2'd1: begin
                nib       = grp[11:8];
                lead_zero = (grp[15:8] == 8'h00);
            end
            2'd2: begin
                nib       = grp[7:4];
                lead_zero = (grp[15:4] == 12'h000);
            end
            default: begin
                nib       = grp[3:0];
                lead_zero = 1'b0;
            end
        endcase
    end

    always_comb begin
        digit_valid = 1'b0;
        digit_val   = 4'h0;
        digit_pos   = 3'd0;
        digit_blank = 1'b0;
        done        = 1'b0;
        busy        = (state_q != S_IDLE);
        case (state_q)
            S_SEND: begin
                digit_valid = 1'b1;
                digit_val   = nib;
                digit_pos   = pos_q;
                digit_blank = (BLANK_LEADING != 0) && lead_zero;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/score_digit_reader.md
# score_digit_reader

Consumer side of the 16-bit packed-BCD score register. On a `start` request it snapshots the score and streams the four BCD digits, most-significant first, to the on-screen text/sprite writer over a valid/ready handshake. It flags leading zeros for blanking. It sits between the score register and the HUD renderer and is normally started once per frame.

## Interface
Parameters:
- `BLANK_LEADING`, default 1: 1 enables leading-zero blank flagging; 0 leaves `digit_blank` at 0.

Ports:
- `Clk`  in  1  system clock.
- `Reset`  in  1  synchronous, active-high; returns the block to IDLE and clears all state.
- `start`  in  1  stream request; sampled only in IDLE.
- `score_in`  in  16  packed BCD score: [15:12] thousands … [3:0] units.
- `digit_ready`  in  1  downstream accepts the current digit.
- `digit_valid`  out  1  a digit is presented.
- `digit_val`  out  4  BCD digit value.
- `digit_pos`  out  3  digit slot index; 0 is the leftmost.
- `digit_blank`  out  1  the digit is a leading zero; renderer draws a space.
- `busy`  out  1  high in every state other than IDLE.
- `done`  out  1  one-cycle pulse after the last digit is accepted.
- `hiscore`  out  16  high-score value; present only with `SCORE_HISCORE_EN`.

## Operation
- FSM states: IDLE, SEND, DONE.
- IDLE:
  - `start`=1 → `snap` <= `score_in`, `pos` <= 0, next state SEND.
  - `start` is ignored in every state other than IDLE; no queueing.
- SEND:
  - `digit_valid`=1.
  - `digit_val` = the nibble of `snap` selected by `pos` (pos 0 → [15:12]).
  - Transfer occurs when `digit_valid` & `digit_ready`.
  - On transfer: `pos`+1. If `pos` is the last slot, next state DONE.
  - Without a transfer, `digit_val`, `digit_pos` and `digit_blank` hold stable. `digit_valid` never drops before a transfer.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Blanking:
  - `digit_blank`=1 iff `BLANK_LEADING`=1, the digit is 0, and every more-significant digit in the same group is 0.
  - The units digit of a group is never blanked, so score 0000 streams as blank, blank, blank, "0".
- Non-BCD nibbles (A–F) pass through unchanged and count as nonzero for blanking. The block performs no correction.
- The snapshot isolates the stream from `score_in` changes mid-stream.

## Timing
- Reset values:
  - `digit_valid`, `digit_blank`, `busy`, `done` = 0.
  - `digit_val`, `digit_pos` = 0.
  - `snap`, `hiscore` = 0.
  - State = IDLE.
- If `start` is high in cycle N, `digit_valid` and `busy` rise in cycle N+1.
- With `digit_ready` held high:
  - 4 digits are presented in cycles N+1..N+4.
  - `done` pulses in N+5, with `busy` still high.
  - The block is back in IDLE at N+6, when a new `start` is accepted.
- Each `digit_ready` low cycle adds one cycle of latency.
- `Reset` mid-stream: IDLE on the next cycle, outputs at reset values, and no `done` pulse.
- Reset has priority over `start` in the same cycle.

## Configuration
- `SCORE_HISCORE_EN` defined:
  - Adds a `hiscore` register and output.
  - On the accepting `start` edge: if `score_in` > `hiscore` (unsigned compare, valid for BCD), `hiscore` <= `score_in`.
  - The high-score snapshot takes the updated value.
  - The stream grows to 8 digits: pos 0–3 are the score, pos 4–7 the high score. Blanking is evaluated separately per group.
  - `done` moves to N+9.
  - `hiscore` is cleared only by `Reset`.
- Not defined: 4-digit stream only, no `hiscore` port, no comparator.

## Test plan
- Reset, then `score_in`=16'h0120, start pulse, `digit_ready`=1 → digits (0,blank)(1)(2)(0) at pos 0..3 in cycles N+1..N+4; `done` at N+5; `busy` high N+1..N+5.
- `score_in`=16'h0000 → three blanked 0s, then a non-blanked 0 at pos 3.
- Score 16'h9876; `digit_ready` low for 3 cycles at pos 1 → `digit_val`=8, pos=1 held stable and `digit_valid` high; `done` delayed 3 cycles to N+8.
- Change `score_in` and pulse `start` mid-stream → streamed digits unchanged, `start` ignored, exactly one `done`.
- Assert `Reset` at pos 2 → `digit_valid`=0 and `busy`=0 the next cycle, no `done`; a fresh `start` restarts at pos 0.
- `SCORE_HISCORE_EN`: stream score 16'h0450, then 16'h0300 → second stream pos 4..7 = blank,4,5,0; `hiscore` stays 16'h0450.
